// File: rtl/timer24_ctrl.sv
// timer24_ctrl: bus-mapped sequencer for an external 24-bit counter (prescaler, one-shot/periodic, sticky match, irq).
// Optional TIMER24_TOGGLE_EN adds tog_out and the CTRL[3] TOG_CLR strobe.
module timer24_ctrl #(
  parameter int DATA_W = 24,
  parameter int PSC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [1:0]        bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic [DATA_W-1:0] cnt_value,
  output logic              cnt_en,
  output logic              cnt_load,
  output logic [DATA_W-1:0] cnt_load_val,
`ifdef TIMER24_TOGGLE_EN
  output logic              tog_out,
`endif
  output logic              irq
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic               mode_q, irq_en_q, match_q, match_d;
  logic [PSC_W-1:0]   psc_val_q, psc_q, psc_d;
  logic [DATA_W-1:0]  compare_q, rdata_q, rdata_d, ctrl_rd;
  logic               ctrl_wr, cmp_wr, stat_wr, cnt_wr, run, tick, match;
  always_comb begin
    ctrl_wr = bus_we && bus_addr == 2'd0;
    cmp_wr  = bus_we && bus_addr == 2'd1;
    stat_wr = bus_we && bus_addr == 2'd2;
    cnt_wr  = bus_we && bus_addr == 2'd3;
    run     = state_q == RUN;
    tick    = run && psc_q == psc_val_q;
    // a COUNT write swallows any coincident tick or match
    match        = tick && !cnt_wr && cnt_value == compare_q;
    cnt_en       = tick && !match && !cnt_wr;
    cnt_load     = cnt_wr || match;
    cnt_load_val = cnt_wr ? bus_wdata : '0;
    state_d = run ? ((ctrl_wr && !bus_wdata[0]) ? IDLE : (match && !mode_q) ? DONE : RUN)
                  : ((ctrl_wr && bus_wdata[0]) ? RUN : state_q);
    psc_d   = (run && state_d == RUN && !tick && !cnt_wr) ? psc_q + PSC_W'(1) : '0;
    match_d = match || (match_q && !(stat_wr && bus_wdata[0]));
    ctrl_rd = '0;
    ctrl_rd[2:0] = {irq_en_q, mode_q, run};
    ctrl_rd[8+:PSC_W] = psc_val_q;
    rdata_d = !bus_re ? rdata_q :
              bus_addr == 2'd0 ? ctrl_rd :
              bus_addr == 2'd1 ? compare_q :
              bus_addr == 2'd2 ? DATA_W'({run, match_q}) : cnt_value;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      psc_val_q <= '0;
      compare_q <= '0;
      match_q   <= 1'b0;
      psc_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      psc_q   <= psc_d;
      rdata_q <= rdata_d;
      if (ctrl_wr) begin
        mode_q    <= bus_wdata[1];
        irq_en_q  <= bus_wdata[2];
        psc_val_q <= bus_wdata[8+:PSC_W];
      end
      if (cmp_wr) compare_q <= bus_wdata;
    end
  end
`ifdef TIMER24_TOGGLE_EN
  logic tog_q, tog_d;
  always_comb tog_d = (ctrl_wr && bus_wdata[3]) ? 1'b0 : tog_q ^ match;
  always_ff @(posedge clk) tog_q <= rst ? 1'b0 : tog_d;
  assign tog_out = tog_q;
`endif
  assign bus_rdata = rdata_q;
  assign irq       = match_q && irq_en_q;
endmodule
